adc_ti_pattern_gen: RTL and testbench

ADC_TI_PATTERN_GEN -- requirements
Module: adc_ti_pattern_gen

---
 rtl/adc_ti_pkg.sv | 26 ++
 rtl/adc_pattern_lane_gen.sv | 70 +++++++
 rtl/adc_ti_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_adc_ti_pattern_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ti_pkg.sv
// Shared encodings for the time-interleaved ADC test-pattern generator:
// pattern modes, FSM states and the PRBS9 polynomial.
package adc_ti_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_TRI   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_PRBS9 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [8:0] PRBS9_SEED = 9'h1FF;
  // x^9 + x^5 + 1: feedback from state bits 8 and 4
  localparam logic [8:0] PRBS9_TAPS = 9'h110;

  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], ^(s & PRBS9_TAPS)};
  endfunction

endpackage

// File: rtl/adc_pattern_lane_gen.sv
// Combinational generator for one fill cycle: produces LANES consecutive
// samples and the generator state that follows the last of them.
module adc_pattern_lane_gen
  import adc_ti_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int LANES = 8
) (
  input  mode_e                  mode_i,
  input  logic [WIDTH-1:0]       step_i,
  input  logic [WIDTH-1:0]       const_i,
  input  logic [WIDTH-1:0]       val_i,
  input  logic                   dir_down_i,
  input  logic [8:0]             lfsr_i,
  output logic [LANES*WIDTH-1:0] samples_o,
  output logic [WIDTH-1:0]       val_o,
  output logic                   dir_down_o,
  output logic [8:0]             lfsr_o
);

  localparam logic [WIDTH:0] MAXV = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] val_c;
  logic             dir_c;
  logic [8:0]       lfsr_c;
  logic [WIDTH:0]   sum_c;

  always_comb begin
    val_c     = val_i;
    dir_c     = dir_down_i;
    lfsr_c    = lfsr_i;
    sum_c     = '0;
    samples_o = '0;
    for (int l = 0; l < LANES; l++) begin
      case (mode_i)
        MODE_RAMP: begin
          samples_o[l*WIDTH +: WIDTH] = val_c;
          val_c = val_c + step_i;
        end
        MODE_TRI: begin
          samples_o[l*WIDTH +: WIDTH] = val_c;
          // one extra bit so the top-of-range overshoot is visible
          sum_c = {1'b0, val_c} + {1'b0, step_i};
          if (!dir_c) begin
            if (sum_c > MAXV) begin
              val_c = MAXV[WIDTH-1:0];
              dir_c = 1'b1;
            end else begin
              val_c = sum_c[WIDTH-1:0];
            end
          end else if (val_c < step_i) begin
            val_c = '0;
            dir_c = 1'b0;
          end else begin
            val_c = val_c - step_i;
          end
        end
        MODE_CONST: samples_o[l*WIDTH +: WIDTH] = const_i;
        default: begin
          samples_o[l*WIDTH +: WIDTH] = WIDTH'(lfsr_c);
          lfsr_c = prbs9_next(lfsr_c);
        end
      endcase
    end
    val_o      = val_c;
    dir_down_o = dir_c;
    lfsr_o     = lfsr_c;
  end

endmodule

// File: rtl/adc_ti_pattern_gen.sv
// Frame-based test-pattern source for a time-interleaved ADC datapath: fills a
// NUM_CH-sample frame LANES samples per cycle, then holds it until accepted.
module adc_ti_pattern_gen
  import adc_ti_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int NUM_CH = 96,
  parameter int LANES  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              cfg_mode,
  input  logic [WIDTH-1:0]        cfg_step,
  input  logic [WIDTH-1:0]        cfg_const,
  input  logic [15:0]             cfg_num_frames,
  input  logic [NUM_CH-1:0]       cfg_ch_mask,
  output logic [NUM_CH*WIDTH-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             frame_cnt
);

  localparam int NBLK  = NUM_CH / LANES;
  localparam int PTR_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  mode_e                   mode_q;
  logic [WIDTH-1:0]        step_q, const_q, val_q, val_nx;
  logic [15:0]             nframes_q, cnt_q, cnt_inc;
  logic [NUM_CH-1:0]       mask_q;
  logic                    dir_q, dir_nx, done_q;
  logic [8:0]              lfsr_q, lfsr_nx;
  logic [LANES*WIDTH-1:0]  lane_samp;
  logic [NUM_CH*WIDTH-1:0] frame_q, frame_d;
  logic                    start_ok, hold_accept, last_frame;

  assign start_ok    = (state_q == ST_IDLE) && start && !stop;
  assign hold_accept = (state_q == ST_HOLD) && frame_ready && !stop;
  assign cnt_inc     = cnt_q + 16'd1;
  assign last_frame  = (nframes_q != 16'd0) && (cnt_inc == nframes_q);

  adc_pattern_lane_gen #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_gen (
    .mode_i     (mode_q),
    .step_i     (step_q),
    .const_i    (const_q),
    .val_i      (val_q),
    .dir_down_i (dir_q),
    .lfsr_i     (lfsr_q),
    .samples_o  (lane_samp),
    .val_o      (val_nx),
    .dir_down_o (dir_nx),
    .lfsr_o     (lfsr_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_FILL;
        ST_FILL: if (ptr_q == PTR_W'(NBLK - 1)) state_d = ST_HOLD;
        ST_HOLD: if (frame_ready) state_d = last_frame ? ST_IDLE : ST_FILL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_valid = (state_q == ST_HOLD);
    busy        = (state_q != ST_IDLE);
  end

  assign ptr_d = ((state_q == ST_FILL) && (state_d == ST_FILL)) ? ptr_q + PTR_W'(1) : '0;

  // masked channels still consume a generator step; only the stored value is zeroed
  always_comb begin
    frame_d = frame_q;
    if (state_q == ST_FILL) begin
      for (int b = 0; b < NBLK; b++) begin
        if (ptr_q == PTR_W'(b)) begin
          for (int l = 0; l < LANES; l++) begin
            frame_d[(b*LANES+l)*WIDTH +: WIDTH] =
              mask_q[b*LANES+l] ? lane_samp[l*WIDTH +: WIDTH] : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      mode_q    <= MODE_RAMP;
      step_q    <= '0;
      const_q   <= '0;
      nframes_q <= '0;
      mask_q    <= '0;
      val_q     <= '0;
      dir_q     <= 1'b0;
      lfsr_q    <= PRBS9_SEED;
      frame_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      done_q <= hold_accept && last_frame;
      if (start_ok) begin
        mode_q    <= mode_e'(cfg_mode);
        step_q    <= cfg_step;
        const_q   <= cfg_const;
        nframes_q <= cfg_num_frames;
        mask_q    <= cfg_ch_mask;
        val_q     <= cfg_const;
        dir_q     <= 1'b0;
        lfsr_q    <= PRBS9_SEED;
        cnt_q     <= '0;
      end
      if ((state_q == ST_FILL) && !stop) begin
        val_q   <= val_nx;
        dir_q   <= dir_nx;
        lfsr_q  <= lfsr_nx;
        frame_q <= frame_d;
      end
      if (hold_accept) cnt_q <= cnt_inc;
    end
  end

  assign frame_data = frame_q;
  assign done       = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_adc_ti_pattern_gen.sv
// Scoreboard bench for adc_ti_pattern_gen: expected frames are queued as runs
// are launched and a monitor compares each frame the consumer accepts.
module tb_adc_ti_pattern_gen;

  localparam int W   = 9;
  localparam int NCH = 96;
  localparam int LN  = 8;
  localparam int FW  = NCH * W;

  logic           clk = 1'b0;
  logic           reset, start, stop, frame_ready;
  logic [1:0]     cfg_mode;
  logic [W-1:0]   cfg_step, cfg_const;
  logic [15:0]    cfg_num_frames, frame_cnt;
  logic [NCH-1:0] cfg_ch_mask;
  logic [FW-1:0]  frame_data;
  logic           frame_valid, busy, done;

  int checks   = 0;
  int failures = 0;
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  adc_ti_pattern_gen #(.WIDTH(W), .NUM_CH(NCH), .LANES(LN)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .cfg_mode       (cfg_mode),
    .cfg_step       (cfg_step),
    .cfg_const      (cfg_const),
    .cfg_num_frames (cfg_num_frames),
    .cfg_ch_mask    (cfg_ch_mask),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .busy           (busy),
    .done           (done),
    .frame_cnt      (frame_cnt)
  );

  // Monitor: every accepted frame is checked against the head of the queue
  always @(negedge clk) begin
    logic [FW-1:0] e;
    int bad;
    if (!reset && frame_valid && frame_ready && !stop) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: frame accepted with nothing queued, frame_cnt=%0d", frame_cnt);
      end else begin
        e   = exp_q.pop_front();
        bad = -1;
        for (int k = NCH - 1; k >= 0; k--)
          if (frame_data[k*W +: W] !== e[k*W +: W]) bad = k;
        if (bad >= 0) begin
          failures++;
          $display("FAIL sb_frame ch=%0d actual=0x%0h expected=0x%0h",
                   bad, frame_data[bad*W +: W], e[bad*W +: W]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] chan(input int k);
    return 32'(frame_data[k*W +: W]);
  endfunction

  // Reference patterns, built directly from the pattern definitions
  task automatic push_frames(input int mode, input int step, input int cst, input int nf,
                             input logic [NCH-1:0] mask);
    logic [FW-1:0] f;
    logic [8:0]    s  = 9'h1FF;
    int            v  = cst;
    bit            dn = 1'b0;
    int            n  = 0;
    int            smp;
    for (int fr = 0; fr < nf; fr++) begin
      f = '0;
      for (int k = 0; k < NCH; k++) begin
        case (mode)
          0: smp = (cst + n * step) & ((1 << W) - 1);
          1: begin
            smp = v;
            if (!dn) begin
              if (v + step > (1 << W) - 1) begin v = (1 << W) - 1; dn = 1'b1; end
              else v = v + step;
            end else if (v < step) begin
              v = 0; dn = 1'b0;
            end else v = v - step;
          end
          2: smp = cst;
          default: begin
            smp = int'(s);
            s   = {s[7:0], s[8] ^ s[4]};
          end
        endcase
        f[k*W +: W] = mask[k] ? W'(smp) : '0;
        n++;
      end
      exp_q.push_back(f);
    end
  endtask

  // Start a run, then scramble cfg_* so any use of live config shows up
  task automatic do_start(input int mode, input int step, input int cst, input int nf,
                          input logic [NCH-1:0] mask);
    cfg_mode       = 2'(mode);
    cfg_step       = W'(step);
    cfg_const      = W'(cst);
    cfg_num_frames = 16'(nf);
    cfg_ch_mask    = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode       = ~cfg_mode;
    cfg_step       = cfg_step + 9'd3;
    cfg_const      = ~cfg_const;
    cfg_num_frames = cfg_num_frames + 16'd1;
    cfg_ch_mask    = ~cfg_ch_mask;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cnt_clear", 32'(frame_cnt), 32'd0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!frame_valid && n < 200) begin
      tick();
      n++;
    end
    if (!frame_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid timeout actual=%0d cycles required=12", n);
    end
  endtask

  task automatic accept_frames(input int nf);
    int n;
    for (int i = 0; i < nf; i++) begin
      wait_valid(n);
      chk("valid_latency", 32'(n), 32'd12);
      tick();
    end
  endtask

  task automatic check_done(input int nf);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_idle", 32'(busy), 32'd0);
    chk("done_cnt", 32'(frame_cnt), 32'(nf));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  int             n;
  int             samp[NCH*6];
  bit             seen[512];
  bit             ok;
  logic [NCH-1:0] m;
  logic [FW-1:0]  snap;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; frame_ready = 1'b0;
    cfg_mode = '0; cfg_step = '0; cfg_const = '0; cfg_num_frames = '0; cfg_ch_mask = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_data_zero", 32'(frame_data == '0), 32'd1);
    reset = 1'b0;
    tick();

    // RAMP from 0 step 1, two frames
    frame_ready = 1'b1;
    push_frames(0, 1, 0, 2, '1);
    do_start(0, 1, 0, 2, '1);
    accept_frames(2);
    check_done(2);

    // TRIANGLE from 500 step 8: clips at 511, descends to 7, clips at 0, ascends
    push_frames(1, 8, 500, 2, '1);
    do_start(1, 8, 500, 2, '1);
    wait_valid(n);
    chk("tri_latency", 32'(n), 32'd12);
    chk("tri_s0", chan(0), 32'd500);
    chk("tri_s1", chan(1), 32'd508);
    chk("tri_s2", chan(2), 32'd511);
    chk("tri_s3", chan(3), 32'd503);
    chk("tri_s4", chan(4), 32'd495);
    chk("tri_s65", chan(65), 32'd7);
    chk("tri_s66", chan(66), 32'd0);
    chk("tri_s67", chan(67), 32'd8);
    tick();
    accept_frames(1);
    check_done(2);

    // PRBS9 over six frames: full period plus wrap
    push_frames(3, 0, 0, 6, '1);
    do_start(3, 0, 0, 6, '1);
    for (int f = 0; f < 6; f++) begin
      wait_valid(n);
      for (int k = 0; k < NCH; k++) samp[f*NCH+k] = int'(frame_data[k*W +: W]);
      tick();
    end
    check_done(6);
    chk("prbs_s0", 32'(samp[0]), 32'h1FF);
    chk("prbs_s1", 32'(samp[1]), 32'h1FE);
    ok = 1'b1;
    for (int i = 0; i < 511; i++) begin
      if (samp[i] == 0 || seen[samp[i]]) ok = 1'b0;
      seen[samp[i]] = 1'b1;
    end
    chk("prbs_distinct", 32'(ok), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 65; i++) if (samp[511+i] != samp[i]) ok = 1'b0;
    chk("prbs_repeat", 32'(ok), 32'd1);

    // CONST 0x0AA with channel 5 masked, consumer stalls for 20 cycles
    frame_ready = 1'b0;
    m = '1;
    m[5] = 1'b0;
    do_start(2, 0, 'h0AA, 1, m);
    wait_valid(n);
    chk("const_latency", 32'(n), 32'd12);
    snap = frame_data;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_valid", 32'(frame_valid), 32'd1);
      chk("stall_stable", 32'(frame_data === snap), 32'd1);
    end
    chk("stall_cnt", 32'(frame_cnt), 32'd0);
    chk("mask_ch5", chan(5), 32'd0);
    chk("mask_ch0", chan(0), 32'h0AA);
    chk("mask_ch95", chan(95), 32'h0AA);
    push_frames(2, 0, 'h0AA, 1, m);
    frame_ready = 1'b1;
    tick();
    check_done(1);

    // stop and start in the same IDLE cycle: stop wins
    cfg_mode = 2'd0; cfg_num_frames = 16'd1; cfg_ch_mask = '1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_beats_start", 32'(busy), 32'd0);

    // stop during FILL
    do_start(0, 2, 3, 1, '1);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stopfill_busy", 32'(busy), 32'd0);
    chk("stopfill_valid", 32'(frame_valid), 32'd0);
    chk("stopfill_done", 32'(done), 32'd0);
    ok = 1'b1;
    repeat (15) begin
      tick();
      if (frame_valid || done || busy) ok = 1'b0;
    end
    chk("stopfill_quiet", 32'(ok), 32'd1);

    // stop during HOLD, with frame_ready raised in the same cycle
    frame_ready = 1'b0;
    do_start(2, 0, 'h55, 1, '1);
    wait_valid(n);
    stop = 1'b1; frame_ready = 1'b1;
    tick();
    stop = 1'b0; frame_ready = 1'b0;
    chk("stophold_valid", 32'(frame_valid), 32'd0);
    chk("stophold_busy", 32'(busy), 32'd0);
    chk("stophold_done", 32'(done), 32'd0);
    chk("stophold_cnt", 32'(frame_cnt), 32'd0);
    tick();
    chk("stophold_nodone", 32'(done), 32'd0);

    // continuous RAMP: three frames, run keeps going until stopped
    frame_ready = 1'b1;
    push_frames(0, 7, 5, 3, '1);
    do_start(0, 7, 5, 0, '1);
    accept_frames(3);
    chk("cont_busy", 32'(busy), 32'd1);
    chk("cont_done", 32'(done), 32'd0);
    chk("cont_cnt", 32'(frame_cnt), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 32'(busy), 32'd0);

    // asynchronous reset mid-FILL, then a clean PRBS restart
    do_start(3, 0, 0, 1, '1);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data_zero", 32'(frame_data == '0), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    push_frames(3, 0, 0, 1, '1);
    do_start(3, 0, 0, 1, '1);
    accept_frames(1);
    check_done(1);

    repeat (2) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
